// File: rtl/register_file_pkg.sv
// ---------------------------------------------------------------------------
// register_file_pkg
// Constants and types shared by the general-purpose register file and its
// write-address decoder.
// ---------------------------------------------------------------------------
package register_file_pkg;

  localparam int REG_COUNT      = 32;
  localparam int REG_ADDR_W     = 5;
  localparam int DATA_W_DEFAULT = 32;
  localparam int R0_IDX         = 0;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [REG_COUNT-1:0]  reg_strobe_t;

  localparam reg_addr_t R0_ADDR = reg_addr_t'(R0_IDX);

endpackage : register_file_pkg

// File: rtl/register_file_decoder5to32.sv
// ---------------------------------------------------------------------------
// decoder5to32
// 5-to-32 one-hot write-address decoder. Exactly one strobe bit is high when
// en=1, none when en=0.
//
// Ports
//   en : decode enable
//   a  : 5-bit register index
//   y  : one-hot strobes, bit i selects register i
// ---------------------------------------------------------------------------
module decoder5to32
  import register_file_pkg::*;
(
  input  logic        en,
  input  reg_addr_t   a,
  output reg_strobe_t y
);

  // NOTE: every output of a combinational block gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    y = '0;
    if (en) y[a] = 1'b1;
  end

endmodule : decoder5to32

// File: rtl/register_file.sv
// ---------------------------------------------------------------------------
// register_file
// 32 x DATA_W general-purpose register file: one write port driven through
// the one-hot write decoder, two registered read ports (1-cycle latency)
// with same-cycle write-to-read bypass. With ZERO_R0=1, R0 is hard-wired 0.
//
// Ports
//   clk, resetn            : clock, asynchronous active-low reset
//   wr_en/wr_addr/wr_data  : write request, index, data
//   rd_enN/rd_addrN        : read capture enable and index, port N (1,2)
//   rd_dataN               : registered read data, port N
//   rd_validN              : rd_dataN was captured on the previous edge
// ---------------------------------------------------------------------------
module register_file
  import register_file_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEFAULT,
  parameter bit ZERO_R0 = 1'b1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              wr_en,
  input  reg_addr_t         wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en1,
  input  reg_addr_t         rd_addr1,
  input  logic              rd_en2,
  input  reg_addr_t         rd_addr2,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2,
  output logic              rd_valid1,
  output logic              rd_valid2
);

  reg_strobe_t       w_dec_strobe;
  reg_strobe_t       w_wr_strobe;
  logic [DATA_W-1:0] w_rd_next1;
  logic [DATA_W-1:0] w_rd_next2;

  logic [DATA_W-1:0] r_regs [REG_COUNT];
  logic [DATA_W-1:0] r_rd_data1;
  logic [DATA_W-1:0] r_rd_data2;
  logic              r_rd_valid1;
  logic              r_rd_valid2;

  decoder5to32 u_decoder (
    .en (wr_en),
    .a  (wr_addr),
    .y  (w_dec_strobe)
  );

  // R0's strobe is masked so its storage never leaves the reset value and
  // can be trimmed away by synthesis.
  always_comb begin
    w_wr_strobe = w_dec_strobe;
    if (ZERO_R0) w_wr_strobe[R0_IDX] = 1'b0;
  end

  // NOTE: this storage array carries an asynchronous reset because every
  // register must read 0 right after reset; that rules out RAM inference,
  // so the file is built from flops.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < REG_COUNT; i++) r_regs[i] <= '0;
    end else begin
      // NOTE: sequential state always uses non-blocking assignments so all
      // flops sample pre-edge values regardless of statement order.
      for (int i = 0; i < REG_COUNT; i++) begin
        if (w_wr_strobe[i]) r_regs[i] <= wr_data;
      end
    end
  end

  // Read muxes with bypass: a write to the addressed register in the same
  // cycle wins over the stale stored value; R0 overrides both when zeroed.
  always_comb begin
    w_rd_next1 = r_regs[rd_addr1];
    if (wr_en && (wr_addr == rd_addr1)) w_rd_next1 = wr_data;
    if (ZERO_R0 && (rd_addr1 == R0_ADDR)) w_rd_next1 = '0;

    w_rd_next2 = r_regs[rd_addr2];
    if (wr_en && (wr_addr == rd_addr2)) w_rd_next2 = wr_data;
    if (ZERO_R0 && (rd_addr2 == R0_ADDR)) w_rd_next2 = '0;
  end

  // Read data holds when its port is idle; valid flags one-cycle pulses.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_rd_data1  <= '0;
      r_rd_data2  <= '0;
      r_rd_valid1 <= 1'b0;
      r_rd_valid2 <= 1'b0;
    end else begin
      r_rd_valid1 <= rd_en1;
      r_rd_valid2 <= rd_en2;
      if (rd_en1) r_rd_data1 <= w_rd_next1;
      if (rd_en2) r_rd_data2 <= w_rd_next2;
    end
  end

  assign rd_data1  = r_rd_data1;
  assign rd_data2  = r_rd_data2;
  assign rd_valid1 = r_rd_valid1;
  assign rd_valid2 = r_rd_valid2;

endmodule : register_file

// File: tb/tb_register_file.sv
// ---------------------------------------------------------------------------
// tb_register_file
// Drives two register_file instances in lockstep (ZERO_R0=1 and ZERO_R0=0)
// and compares both against a behavioural model: a plain array per
// instance, updated with the write first and then read, which expresses the
// "read returns the new value" rule directly.
// ---------------------------------------------------------------------------
module tb_register_file;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        wr_en = 1'b0;
  logic [4:0]  wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic        rd_en1 = 1'b0;
  logic [4:0]  rd_addr1 = '0;
  logic        rd_en2 = 1'b0;
  logic [4:0]  rd_addr2 = '0;

  logic [31:0] z_data1, z_data2, n_data1, n_data2;
  logic        z_valid1, z_valid2, n_valid1, n_valid2;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state, index 0 = ZERO_R0 instance, 1 = ordinary-R0 instance.
  logic [31:0] mem       [2][32];
  logic [31:0] exp_data  [2][2];
  logic        exp_valid [2][2];

  always #5 clk = ~clk;

  register_file #(.DATA_W(32), .ZERO_R0(1'b1)) dut_z (
    .clk(clk), .resetn(resetn),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en1(rd_en1), .rd_addr1(rd_addr1), .rd_en2(rd_en2), .rd_addr2(rd_addr2),
    .rd_data1(z_data1), .rd_data2(z_data2), .rd_valid1(z_valid1), .rd_valid2(z_valid2)
  );

  register_file #(.DATA_W(32), .ZERO_R0(1'b0)) dut_n (
    .clk(clk), .resetn(resetn),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en1(rd_en1), .rd_addr1(rd_addr1), .rd_en2(rd_en2), .rd_addr2(rd_addr2),
    .rd_data1(n_data1), .rd_data2(n_data2), .rd_valid1(n_valid1), .rd_valid2(n_valid2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      for (int i = 0; i < 32; i++) mem[c][i] = '0;
      for (int p = 0; p < 2; p++) begin
        exp_data[c][p]  = '0;
        exp_valid[c][p] = 1'b0;
      end
    end
  endtask

  // Apply this cycle's write to a copy of storage, then read from the copy.
  task automatic model_step();
    logic [31:0] nm [32];
    for (int c = 0; c < 2; c++) begin
      for (int i = 0; i < 32; i++) nm[i] = mem[c][i];
      if (wr_en && !(c == 0 && wr_addr == 5'd0)) nm[wr_addr] = wr_data;
      if (rd_en1) exp_data[c][0] = nm[rd_addr1];
      if (rd_en2) exp_data[c][1] = nm[rd_addr2];
      exp_valid[c][0] = rd_en1;
      exp_valid[c][1] = rd_en2;
      for (int i = 0; i < 32; i++) mem[c][i] = nm[i];
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, " z.rd_data1"},  z_data1,  exp_data[0][0]);
    check({tag, " z.rd_data2"},  z_data2,  exp_data[0][1]);
    check({tag, " z.rd_valid1"}, 32'(z_valid1), 32'(exp_valid[0][0]));
    check({tag, " z.rd_valid2"}, 32'(z_valid2), 32'(exp_valid[0][1]));
    check({tag, " n.rd_data1"},  n_data1,  exp_data[1][0]);
    check({tag, " n.rd_data2"},  n_data2,  exp_data[1][1]);
    check({tag, " n.rd_valid1"}, 32'(n_valid1), 32'(exp_valid[1][0]));
    check({tag, " n.rd_valid2"}, 32'(n_valid2), 32'(exp_valid[1][1]));
  endtask

  // Called at a falling edge with inputs already set; returns at the next
  // falling edge after checking outputs 1 time unit past the rising edge.
  task automatic cycle(input string tag);
    model_step();
    @(posedge clk);
    #1;
    check_outputs(tag);
    @(negedge clk);
  endtask

  task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic re1, input logic [4:0] ra1,
                       input logic re2, input logic [4:0] ra2);
    wr_en = we; wr_addr = wa; wr_data = wd;
    rd_en1 = re1; rd_addr1 = ra1; rd_en2 = re2; rd_addr2 = ra2;
  endtask

  typedef struct {
    string       name;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        re1;
    logic [4:0]  ra1;
    logic        re2;
    logic [4:0]  ra2;
    logic [31:0] z1, z2, n1, n2;   // expected read data after the edge
  } vec_t;

  vec_t vecs [9];

  initial begin
    vecs[0] = '{"wr_r7",        1, 7, 32'h1234_5678, 0, 0, 0, 0, 0, 0, 0, 0};
    vecs[1] = '{"rd_r7",        0, 0, 0,             1, 7, 0, 7, 32'h1234_5678, 0, 32'h1234_5678, 0};
    vecs[2] = '{"bypass_r3",    1, 3, 32'hA5A5_A5A5, 1, 3, 1, 3,
                32'hA5A5_A5A5, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 32'hA5A5_A5A5};
    vecs[3] = '{"r0_bypass",    1, 0, 32'hFFFF_FFFF, 1, 0, 1, 0,
                0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    vecs[4] = '{"r0_read",      0, 0, 0,             1, 0, 1, 7,
                0, 32'h1234_5678, 32'hFFFF_FFFF, 32'h1234_5678};
    vecs[5] = '{"no_wr_r9",     0, 9, 32'h55,        1, 9, 0, 0,
                0, 32'h1234_5678, 0, 32'h1234_5678};
    vecs[6] = '{"rd_r9_r3",     0, 0, 0,             1, 9, 1, 3,
                0, 32'hA5A5_A5A5, 0, 32'hA5A5_A5A5};
    vecs[7] = '{"wr_only_r9",   1, 9, 32'h55,        0, 9, 0, 9,
                0, 32'hA5A5_A5A5, 0, 32'hA5A5_A5A5};
    vecs[8] = '{"rd_r9_hold2",  0, 0, 0,             1, 9, 0, 0,
                32'h55, 32'hA5A5_A5A5, 32'h55, 32'hA5A5_A5A5};

    // Power-on reset.
    model_reset();
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check_outputs("reset");
    resetn = 1'b1;
    @(negedge clk);

    // Directed table.
    for (int v = 0; v < 9; v++) begin
      drive(vecs[v].we, vecs[v].wa, vecs[v].wd, vecs[v].re1, vecs[v].ra1,
            vecs[v].re2, vecs[v].ra2);
      cycle(vecs[v].name);
      check({vecs[v].name, " tbl z1"}, z_data1, vecs[v].z1);
      check({vecs[v].name, " tbl z2"}, z_data2, vecs[v].z2);
      check({vecs[v].name, " tbl n1"}, n_data1, vecs[v].n1);
      check({vecs[v].name, " tbl n2"}, n_data2, vecs[v].n2);
    end

    // Isolation sweep: write R_i = i*0x01010101, then read back on
    // alternating ports, then re-read every register on both ports.
    for (int i = 1; i < 32; i++) begin
      drive(1, 5'(i), 32'(i) * 32'h0101_0101, 0, 0, 0, 0);
      cycle("sweep_wr");
    end
    for (int i = 1; i < 32; i++) begin
      if (i % 2 == 1) drive(0, 0, 0, 1, 5'(i), 0, 0);
      else            drive(0, 0, 0, 0, 0, 1, 5'(i));
      cycle("sweep_rd");
      if (i % 2 == 1) check("sweep exact p1", z_data1, 32'(i) * 32'h0101_0101);
      else            check("sweep exact p2", z_data2, 32'(i) * 32'h0101_0101);
    end
    for (int i = 0; i < 32; i++) begin
      drive(0, 0, 0, 1, 5'(i), 1, 5'((i + 1) % 32));
      cycle("sweep_all");
    end

    // Asynchronous reset: load R5, read it, then drop resetn mid-cycle.
    drive(1, 5, 32'hDEAD_BEEF, 1, 5, 1, 5);
    cycle("r5_load");
    drive(0, 0, 0, 0, 0, 0, 0);
    #2 resetn = 1'b0;
    model_reset();
    #1;
    check_outputs("async_reset");
    check("async_reset r5 z", z_data1, 32'h0);
    // Write attempted while reset is held across an edge is lost.
    drive(1, 5, 32'hCAFE_F00D, 0, 0, 0, 0);
    @(negedge clk);
    resetn = 1'b1;
    drive(0, 0, 0, 1, 5, 1, 5);
    cycle("r5_after_reset");
    check("r5_after_reset value", n_data2, 32'h0);

    // Random traffic; write address often collides with read addresses.
    for (int t = 0; t < 400; t++) begin
      logic [4:0] ra1, ra2, wa;
      ra1 = 5'($urandom_range(0, 31));
      ra2 = ($urandom_range(0, 3) == 0) ? ra1 : 5'($urandom_range(0, 31));
      case ($urandom_range(0, 3))
        0:       wa = ra1;
        1:       wa = ra2;
        2:       wa = 5'd0;
        default: wa = 5'($urandom_range(0, 31));
      endcase
      drive(1'($urandom), wa, $urandom, 1'($urandom), ra1, 1'($urandom), ra2);
      cycle("random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule : tb_register_file
